// File: rtl/dc_remover_mc.sv
// Multi-channel windowed DC remover and peak-to-peak meter.
// Gathers max/min/sum per window of 2^LOG2_WIN strobes and subtracts the last window's offset.
module dc_remover_mc #(
  parameter int N        = 8,
  parameter int CH       = 2,
  parameter int LOG2_WIN = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sample_en,
  input  logic [CH*N-1:0] data_in,
  input  logic            mode,
  input  logic            clear,
  output logic [CH*N-1:0] data_out,
  output logic            out_valid,
  output logic [CH*N-1:0] vpp,
  output logic [CH*N-1:0] dc_offset,
  output logic            stats_valid,
  output logic            offset_ready
);

  localparam int SW = N + LOG2_WIN;
  localparam logic [LOG2_WIN-1:0] LAST = '1;

  function automatic logic signed [N-1:0] sat_n(input logic signed [N:0] v);
    logic signed [N-1:0] r;
    if (v[N] != v[N-1]) r = v[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    else                r = v[N-1:0];
    return r;
  endfunction

  logic [LOG2_WIN-1:0] r_cnt;
  logic [N-1:0]        r_max  [CH];
  logic [N-1:0]        r_min  [CH];
  logic [SW-1:0]       r_sum  [CH];
  logic [N-1:0]        r_vpp  [CH];
  logic [N-1:0]        r_dc   [CH];
  logic signed [N-1:0] r_dout [CH];
  logic                r_out_valid;
  logic                r_stats_valid;
  logic                r_offset_ready;

  logic [N-1:0]        w_x    [CH];
  logic [N-1:0]        w_max  [CH];
  logic [N-1:0]        w_min  [CH];
  logic [SW-1:0]       w_sum  [CH];
  logic [N:0]          w_mid  [CH];
  logic [N-1:0]        w_dc   [CH];
  logic signed [N:0]   w_diff [CH];
  logic                w_fold;
  logic                w_close;

  assign w_fold  = sample_en && !clear;
  assign w_close = w_fold && (r_cnt == LAST);

  // Fold the current sample in combinationally so a closing window includes it.
  always_comb begin
    for (int k = 0; k < CH; k++) begin
      w_x[k]    = data_in[k*N +: N];
      w_max[k]  = (w_x[k] > r_max[k]) ? w_x[k] : r_max[k];
      w_min[k]  = (w_x[k] < r_min[k]) ? w_x[k] : r_min[k];
      w_sum[k]  = r_sum[k] + {{LOG2_WIN{1'b0}}, w_x[k]};
      w_mid[k]  = {1'b0, w_max[k]} + {1'b0, w_min[k]};
      w_dc[k]   = mode ? w_sum[k][SW-1:LOG2_WIN] : w_mid[k][N:1];
      w_diff[k] = $signed({1'b0, w_x[k]}) - $signed({1'b0, r_dc[k]});
    end
  end

  // Window statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_stats_valid  <= 1'b0;
      r_offset_ready <= 1'b0;
      for (int k = 0; k < CH; k++) begin
        r_max[k] <= '0;
        r_min[k] <= '1;
        r_sum[k] <= '0;
        r_vpp[k] <= '0;
        r_dc[k]  <= '0;
      end
    end else begin
      r_stats_valid <= w_close;
      if (clear || w_close) begin
        r_cnt <= '0;
        for (int k = 0; k < CH; k++) begin
          r_max[k] <= '0;
          r_min[k] <= '1;
          r_sum[k] <= '0;
        end
      end else if (w_fold) begin
        r_cnt <= r_cnt + 1'b1;
        for (int k = 0; k < CH; k++) begin
          r_max[k] <= w_max[k];
          r_min[k] <= w_min[k];
          r_sum[k] <= w_sum[k];
        end
      end
      if (w_close) begin
        r_offset_ready <= 1'b1;
        for (int k = 0; k < CH; k++) begin
          r_vpp[k] <= w_max[k] - w_min[k];
          r_dc[k]  <= w_dc[k];
        end
      end
    end
  end

  // DC removal: subtracts the offset registered before this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      for (int k = 0; k < CH; k++) r_dout[k] <= '0;
    end else begin
      r_out_valid <= sample_en && r_offset_ready;
      if (sample_en && r_offset_ready) begin
        for (int k = 0; k < CH; k++) r_dout[k] <= sat_n(w_diff[k]);
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_pack
    assign data_out[g*N +: N]  = r_dout[g];
    assign vpp[g*N +: N]       = r_vpp[g];
    assign dc_offset[g*N +: N] = r_dc[g];
  end

  assign out_valid    = r_out_valid;
  assign stats_valid  = r_stats_valid;
  assign offset_ready = r_offset_ready;

endmodule

// File: tb/tb_dc_remover_mc.sv
// Bench for dc_remover_mc: directed plus random strobes checked against a window-list model.
module tb_dc_remover_mc;
  localparam int N = 8, CH = 2, L = 3, WIN = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sample_en;
  logic [CH*N-1:0] data_in;
  logic            mode;
  logic            clear;
  logic [CH*N-1:0] data_out;
  logic            out_valid;
  logic [CH*N-1:0] vpp;
  logic [CH*N-1:0] dc_offset;
  logic            stats_valid;
  logic            offset_ready;

  dc_remover_mc #(.N(N), .CH(CH), .LOG2_WIN(L)) dut (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .data_in(data_in),
    .mode(mode), .clear(clear), .data_out(data_out), .out_valid(out_valid),
    .vpp(vpp), .dc_offset(dc_offset), .stats_valid(stats_valid),
    .offset_ready(offset_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  // Model: list of samples gathered in the open window plus published results.
  int m_win [CH][WIN];
  int m_n;
  int m_dc [CH], m_vpp [CH], m_dout [CH];
  bit m_rdy, m_sv, m_ov;

  function automatic int satf(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic model_reset();
    m_n = 0; m_rdy = 0; m_sv = 0; m_ov = 0;
    for (int k = 0; k < CH; k++) begin
      m_dc[k] = 0; m_vpp[k] = 0; m_dout[k] = 0;
    end
  endtask

  task automatic model_edge(input bit en, input bit clr, input bit md, input int d0, input int d1);
    int d [CH];
    int mx, mn, sm;
    d[0] = d0; d[1] = d1;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_ov = en && m_rdy;
    if (m_ov) for (int k = 0; k < CH; k++) m_dout[k] = satf(d[k] - m_dc[k]);
    m_sv = 0;
    if (clr) m_n = 0;
    else if (en) begin
      for (int k = 0; k < CH; k++) m_win[k][m_n] = d[k];
      m_n++;
      if (m_n == WIN) begin
        for (int k = 0; k < CH; k++) begin
          mx = 0; mn = 255; sm = 0;
          for (int i = 0; i < WIN; i++) begin
            if (m_win[k][i] > mx) mx = m_win[k][i];
            if (m_win[k][i] < mn) mn = m_win[k][i];
            sm += m_win[k][i];
          end
          m_vpp[k] = mx - mn;
          m_dc[k]  = md ? sm / WIN : (mx + mn) / 2;
        end
        m_rdy = 1; m_sv = 1; m_n = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_ov"}, 32'(out_valid), 32'(m_ov));
    chk({tag, "_sv"}, 32'(stats_valid), 32'(m_sv));
    chk({tag, "_rdy"}, 32'(offset_ready), 32'(m_rdy));
    for (int k = 0; k < CH; k++) begin
      chk($sformatf("%s_vpp%0d", tag, k), 32'(vpp[k*N +: N]), 32'(m_vpp[k] & 255));
      chk($sformatf("%s_dc%0d", tag, k), 32'(dc_offset[k*N +: N]), 32'(m_dc[k] & 255));
      chk($sformatf("%s_dout%0d", tag, k), 32'(data_out[k*N +: N]), 32'(m_dout[k] & 255));
    end
  endtask

  task automatic step(input string tag, input bit en, input bit clr, input bit md,
                      input int d0, input int d1);
    sample_en = en; clear = clr; mode = md;
    data_in = {8'(d1), 8'(d0)};
    model_edge(en, clr, md, d0, d1);
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; sample_en = 1'b0; clear = 1'b0; mode = 1'b0; data_in = '0;
    model_reset();
    @(posedge clk); #1;

    // Reset held with live strobes
    for (int i = 0; i < 4; i++) step("rst", 1, 0, 0, $urandom_range(0, 255), $urandom_range(0, 255));
    rst_n = 1'b1;

    // Mid-range window; no output during the first window
    for (int i = 0; i < WIN; i++) step("mid", 1, 0, 0, 100 + i, (i % 2) ? 255 : 0);
    chk("mid_vpp0", 32'(vpp[7:0]), 7);
    chk("mid_dc0", 32'(dc_offset[7:0]), 103);
    chk("mid_vpp1", 32'(vpp[15:8]), 255);
    chk("mid_dc1", 32'(dc_offset[15:8]), 127);
    step("idle", 0, 0, 0, 0, 0);

    // Mean mode then saturation in both directions
    for (int i = 0; i < WIN; i++) step("mean", 1, 0, 1, 10, 200);
    chk("mean_dc0", 32'(dc_offset[7:0]), 10);
    chk("mean_dc1", 32'(dc_offset[15:8]), 200);
    step("sat", 1, 0, 1, 250, 0);
    chk("sat_pos", 32'(data_out[7:0]), 32'h7F);
    chk("sat_neg", 32'(data_out[15:8]), 32'h80);
    step("align", 0, 1, 0, 0, 0);

    // Gapped strobes in both modes
    for (int md = 0; md < 2; md++) begin
      for (int i = 0; i < WIN; i++) begin
        step("gap", 1, 0, 1'(md), 50 + i, $urandom_range(0, 255));
        step("gap_idle", 0, 0, 1'(md), 0, 0);
        step("gap_idle", 0, 0, 1'(md), 0, 0);
      end
      chk("gap_dc0", 32'(dc_offset[7:0]), 53);
    end

    // Clear discards a partial window
    for (int i = 0; i < 5; i++) step("clr_pre", 1, 0, 0, 255, 255);
    step("clr", 0, 1, 0, 0, 0);
    for (int i = 0; i < WIN; i++) step("clr_win", 1, 0, 0, 20, 20);
    chk("clr_vpp0", 32'(vpp[7:0]), 0);
    chk("clr_dc0", 32'(dc_offset[7:0]), 20);

    // Clear coincident with a strobe
    for (int i = 0; i < 3; i++) step("cs_pre", 1, 0, 0, 90, 30);
    step("cs", 1, 1, 0, 77, 33);
    chk("cs_ov", 32'(out_valid), 1);
    for (int i = 0; i < WIN; i++) step("cs_win", 1, 0, 0, 40 + i, 60);
    chk("cs_close", 32'(stats_valid), 1);

    // Back-to-back windows
    for (int i = 0; i < 2 * WIN; i++) begin
      step("b2b", 1, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 255));
      if (i == WIN - 1 || i == 2 * WIN - 1) chk("b2b_sv", 32'(stats_valid), 1);
    end

    // Asynchronous reset mid-window
    for (int i = 0; i < 12; i++) step("pre_rst", 1, 0, 0, $urandom_range(0, 255), $urandom_range(0, 255));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    step("in_rst", 1, 0, 0, 5, 5);
    rst_n = 1'b1;
    for (int i = 0; i < WIN + 2; i++) step("post_rst", 1, 0, 1, $urandom_range(0, 255), $urandom_range(0, 255));

    // Random traffic
    for (int i = 0; i < 400; i++)
      step("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 255), $urandom_range(0, 255));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
